// File: rtl/imem_load_arbiter_if.sv
// Signal bundle between imem_load_arbiter and its fetch stage, program loader and memory.
// The arbiter takes the slave view; the surrounding environment takes the master view.
interface imem_load_arbiter_if #(parameter int ADDR_W = 12);
    logic              f_req;
    logic [31:0]       f_addr;
    logic [31:0]       f_rdata;
    logic              f_valid;
    logic              f_stall;
    logic              core_hold;
    logic              ld_start;
    logic              ld_valid;
    logic [31:0]       ld_addr;
    logic [31:0]       ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              ld_busy;
    logic [ADDR_W:0]   ld_count;
    logic              err;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic              mem_clken;
    logic [3:0]        mem_byteenable;
    logic [31:0]       mem_writedata;
    logic [31:0]       mem_readdata;

    modport slave (
        input  f_req, f_addr, ld_start, ld_valid, ld_addr, ld_data, ld_last, mem_readdata,
        output f_rdata, f_valid, f_stall, core_hold, ld_ready, ld_busy, ld_count, err,
               mem_address, mem_chipselect, mem_write, mem_clken, mem_byteenable, mem_writedata
    );

    modport master (
        output f_req, f_addr, ld_start, ld_valid, ld_addr, ld_data, ld_last, mem_readdata,
        input  f_rdata, f_valid, f_stall, core_hold, ld_ready, ld_busy, ld_count, err,
               mem_address, mem_chipselect, mem_write, mem_clken, mem_byteenable, mem_writedata
    );
endinterface

// File: rtl/imem_load_arbiter.sv
// Shares the single-port instruction memory between fetch reads and loader writes,
// draining the in-flight fetch and holding the core while an image is streamed in.
module imem_load_arbiter #(
    parameter int ADDR_W = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    imem_load_arbiter_if.slave   bus
);
    localparam logic [31:0]     NOP       = 32'h0000_0013;
    localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {RUN, DRAIN, LOAD, RELEASE} state_t;

    state_t          state;
    state_t          state_next;
    logic            fetch_take;
    logic            load_take;
    logic            fetch_good;
    logic            load_good;
    logic            rd_pending;
    logic            nop_pending;
    logic            err_q;
    logic [ADDR_W:0] count_q;

    function automatic logic addr_good(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && ((addr >> (ADDR_W + 2)) == 32'd0);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (bus.ld_start) state_next = DRAIN;
            DRAIN:   state_next = LOAD;
            LOAD:    if (bus.ld_valid && bus.ld_last) state_next = RELEASE;
            RELEASE: state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // rst_n gates the fetch path so the memory sees no access while reset is held
    always_comb begin
        fetch_take    = 1'b0;
        load_take     = 1'b0;
        bus.f_stall   = 1'b0;
        bus.core_hold = 1'b0;
        bus.ld_ready  = 1'b0;
        bus.ld_busy   = 1'b0;
        case (state)
            RUN: fetch_take = rst_n && bus.f_req;
            DRAIN, RELEASE: begin
                bus.f_stall   = 1'b1;
                bus.core_hold = 1'b1;
                bus.ld_busy   = 1'b1;
            end
            LOAD: begin
                bus.f_stall   = 1'b1;
                bus.core_hold = 1'b1;
                bus.ld_busy   = 1'b1;
                bus.ld_ready  = 1'b1;
                load_take     = bus.ld_valid;
            end
            default: ;
        endcase
    end

    assign fetch_good         = fetch_take && addr_good(bus.f_addr);
    assign load_good          = load_take && addr_good(bus.ld_addr);
    assign bus.mem_chipselect = fetch_good || load_good;
    assign bus.mem_write      = load_good;
    assign bus.mem_byteenable = bus.mem_chipselect ? 4'hF : 4'h0;
    assign bus.mem_writedata  = load_good ? bus.ld_data : 32'd0;
    assign bus.mem_clken      = rst_n;
    assign bus.mem_address    = load_good  ? bus.ld_addr[ADDR_W+1:2] :
                                fetch_good ? bus.f_addr[ADDR_W+1:2]  : '0;

    // A rejected fetch still completes, but with a NOP in place of memory data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pending  <= 1'b0;
            nop_pending <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= '0;
        end else begin
            rd_pending  <= fetch_take;
            nop_pending <= fetch_take && !fetch_good;
            err_q       <= (fetch_take && !fetch_good) || (load_take && !load_good);
            if (state == RUN && bus.ld_start)
                count_q <= '0;
            else if (load_good && count_q != COUNT_MAX)
                count_q <= count_q + 1'b1;
        end
    end

    assign bus.f_valid  = rd_pending;
    assign bus.f_rdata  = !rd_pending ? 32'd0 : (nop_pending ? NOP : bus.mem_readdata);
    assign bus.err      = err_q;
    assign bus.ld_count = count_q;
endmodule

// File: tb/tb_imem_load_arbiter.sv
// Bench for imem_load_arbiter: a memory model plus a word-level reference of memory
// contents, pending fetch result and load count, driven by directed and random steps.
module tb_imem_load_arbiter;
    localparam int          ADDR_W = 12;
    localparam int          DEPTH  = 1 << ADDR_W;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    imem_load_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
    imem_load_arbiter #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [31:0]       mem [DEPTH];
    logic              preload_en;
    logic [ADDR_W-1:0] preload_addr;
    logic [31:0]       preload_data;

    always @(posedge clk) begin
        if (preload_en)
            mem[preload_addr] <= preload_data;
        else if (bus.mem_clken && bus.mem_chipselect) begin
            if (bus.mem_write) mem[bus.mem_address] <= bus.mem_writedata;
            else               bus.mem_readdata     <= mem[bus.mem_address];
        end
    end

    logic [31:0] ref_mem [DEPTH];
    int          exp_count;
    bit          pend_valid;
    logic [31:0] pend_rdata;
    bit          pend_err;
    int          errors = 0;
    int          checks = 0;

    function automatic bit addr_ok(input logic [31:0] a);
        return ((a & 32'd3) == 32'd0) && (a < 32'(4 * DEPTH));
    endfunction

    function automatic logic [ADDR_W-1:0] word_of(input logic [31:0] a);
        return ADDR_W'(a / 4);
    endfunction

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 8)  return 32'($urandom_range(0, DEPTH - 1)) * 4;
        if (r == 8) return 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
        return 32'h4000 + ($urandom & 32'hFFFF_BFFC);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit freq, input logic [31:0] faddr, input bit start,
                                 input bit lvalid, input logic [31:0] laddr,
                                 input logic [31:0] ldata, input bit last);
        bus.f_req    = freq;
        bus.f_addr   = faddr;
        bus.ld_start = start;
        bus.ld_valid = lvalid;
        bus.ld_addr  = laddr;
        bus.ld_data  = ldata;
        bus.ld_last  = last;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_f_valid"},   32'(bus.f_valid), 32'd0);
        checkOutput({tag, "_f_rdata"},   bus.f_rdata, 32'd0);
        checkOutput({tag, "_f_stall"},   32'(bus.f_stall), 32'd0);
        checkOutput({tag, "_core_hold"}, 32'(bus.core_hold), 32'd0);
        checkOutput({tag, "_ld_ready"},  32'(bus.ld_ready), 32'd0);
        checkOutput({tag, "_ld_busy"},   32'(bus.ld_busy), 32'd0);
        checkOutput({tag, "_ld_count"},  32'(bus.ld_count), 32'd0);
        checkOutput({tag, "_err"},       32'(bus.err), 32'd0);
        checkOutput({tag, "_mem_cs"},    32'(bus.mem_chipselect), 32'd0);
        checkOutput({tag, "_mem_write"}, 32'(bus.mem_write), 32'd0);
        checkOutput({tag, "_mem_addr"},  32'(bus.mem_address), 32'd0);
        checkOutput({tag, "_mem_wdata"}, bus.mem_writedata, 32'd0);
    endtask

    // run_mode: core owns memory; load_mode: loader words accepted; neither: drain/release
    task automatic runCycle(input bit run_mode, input bit load_mode);
        logic [31:0] fa;
        logic [31:0] la;
        bit          hit_cs;
        bit          hit_wr;
        @(negedge clk);
        fa     = bus.f_addr;
        la     = bus.ld_addr;
        hit_wr = load_mode && bus.ld_valid && addr_ok(la);
        hit_cs = (run_mode && bus.f_req && addr_ok(fa)) || hit_wr;
        checkOutput("f_valid", 32'(bus.f_valid), 32'(pend_valid));
        if (pend_valid) checkOutput("f_rdata", bus.f_rdata, pend_rdata);
        checkOutput("err",            32'(bus.err), 32'(pend_err));
        checkOutput("f_stall",        32'(bus.f_stall), 32'(!run_mode));
        checkOutput("core_hold",      32'(bus.core_hold), 32'(!run_mode));
        checkOutput("ld_busy",        32'(bus.ld_busy), 32'(!run_mode));
        checkOutput("ld_ready",       32'(bus.ld_ready), 32'(load_mode));
        checkOutput("ld_count",       32'(bus.ld_count), 32'(exp_count));
        checkOutput("mem_chipselect", 32'(bus.mem_chipselect), 32'(hit_cs));
        checkOutput("mem_write",      32'(bus.mem_write), 32'(hit_wr));
        checkOutput("mem_clken",      32'(bus.mem_clken), 32'd1);
        if (hit_cs) begin
            checkOutput("mem_address", 32'(bus.mem_address), hit_wr ? la / 4 : fa / 4);
            checkOutput("mem_byteenable", 32'(bus.mem_byteenable), 32'hF);
        end
        if (hit_wr) checkOutput("mem_writedata", bus.mem_writedata, bus.ld_data);

        if (run_mode && bus.ld_start) exp_count = 0;
        pend_valid = run_mode && bus.f_req;
        pend_err   = 1'b0;
        if (pend_valid) begin
            if (addr_ok(fa)) pend_rdata = ref_mem[word_of(fa)];
            else begin
                pend_rdata = NOP;
                pend_err   = 1'b1;
            end
        end
        if (load_mode && bus.ld_valid) begin
            if (addr_ok(la)) begin
                ref_mem[word_of(la)] = bus.ld_data;
                if (exp_count < DEPTH) exp_count++;
            end else pend_err = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        preload_en   = 1'b0;
        preload_addr = '0;
        preload_data = '0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        pend_valid = 0;
        pend_rdata = 0;
        pend_err   = 0;
        exp_count  = 0;

        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            preload_en   = 1'b1;
            preload_addr = ADDR_W'(i);
            preload_data = (i == 0) ? 32'h11 : (i == 1) ? 32'h22 : (i == 2) ? 32'h33 : $urandom;
            ref_mem[i]   = preload_data;
        end
        @(negedge clk);
        preload_en = 1'b0;
        checkReset("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed fetch stream and misaligned fetch
        applyStimulus(1, 32'h0, 0, 0, 0, 0, 0);  runCycle(1, 0);
        applyStimulus(1, 32'h4, 0, 0, 0, 0, 0);  runCycle(1, 0);
        applyStimulus(1, 32'h8, 0, 0, 0, 0, 0);  runCycle(1, 0);
        applyStimulus(1, 32'h6, 0, 0, 0, 0, 0);  runCycle(1, 0);
        applyStimulus(0, 32'h0, 0, 0, 0, 0, 0);  runCycle(1, 0);
        runCycle(1, 0);

        for (int i = 0; i < 40; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, rand_addr(), 0, 0, $urandom, $urandom, 0);
            runCycle(1, 0);
        end

        // Load three words while the fetch at 0x10 is still served
        applyStimulus(1, 32'h10, 1, 0, 0, 0, 0);            runCycle(1, 0);
        applyStimulus(1, 32'h14, 0, 0, 0, 0, 0);            runCycle(0, 0);
        applyStimulus(1, 32'h14, 0, 1, 32'h0, $urandom, 0); runCycle(0, 1);
        applyStimulus(1, 32'h14, 1, 1, 32'h4, $urandom, 0); runCycle(0, 1);
        applyStimulus(1, 32'h14, 0, 0, 32'h8, $urandom, 0); runCycle(0, 1);
        applyStimulus(1, 32'h14, 0, 1, 32'h8, $urandom, 1); runCycle(0, 1);
        applyStimulus(1, 32'h14, 0, 0, 0, 0, 0);            runCycle(0, 0);
        checkOutput("ld_count_three", 32'(bus.ld_count), 32'd3);
        applyStimulus(1, 32'h0, 0, 0, 0, 0, 0);  runCycle(1, 0);
        applyStimulus(1, 32'h4, 0, 0, 0, 0, 0);  runCycle(1, 0);
        applyStimulus(1, 32'h8, 0, 0, 0, 0, 0);  runCycle(1, 0);
        applyStimulus(0, 32'h0, 0, 0, 0, 0, 0);  runCycle(1, 0);

        // Random load with gaps, an out-of-range and a misaligned word
        applyStimulus(0, 0, 1, 0, 0, 0, 0);  runCycle(1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);  runCycle(0, 0);
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                applyStimulus(1, rand_addr(), $urandom_range(0, 1), 0, $urandom, $urandom, 1);
                runCycle(0, 1);
            end
            applyStimulus(1, rand_addr(), $urandom_range(0, 1), 1,
                          (i == 5) ? 32'h4000 : (i == 9) ? 32'h6
                                   : 32'($urandom_range(0, DEPTH - 1)) * 4,
                          $urandom, i == 29);
            runCycle(0, 1);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);  runCycle(0, 0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 32'($urandom_range(0, DEPTH - 1)) * 4, 0, 0, 0, 0, 0);
            runCycle(1, 0);
        end

        // Reset asserted mid-load after two words
        applyStimulus(0, 0, 1, 0, 0, 0, 0);                 runCycle(1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);                 runCycle(0, 0);
        applyStimulus(0, 0, 0, 1, 32'h0, $urandom, 0);      runCycle(0, 1);
        applyStimulus(0, 0, 0, 1, 32'h4, $urandom, 0);      runCycle(0, 1);
        applyStimulus(1, 32'h0, 0, 1, 32'h8, $urandom, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkReset("midload_reset");
        pend_valid = 0;
        pend_err   = 0;
        exp_count  = 0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        applyStimulus(1, 32'h0, 0, 0, 0, 0, 0);  runCycle(1, 0);
        applyStimulus(1, 32'h4, 0, 0, 0, 0, 0);  runCycle(1, 0);
        applyStimulus(0, 32'h0, 0, 0, 0, 0, 0);  runCycle(1, 0);

        // Full-depth load plus three extra words to reach saturation
        applyStimulus(0, 0, 1, 0, 0, 0, 0);  runCycle(1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);  runCycle(0, 0);
        for (int i = 0; i < DEPTH + 3; i++) begin
            applyStimulus(0, 0, 0, 1, 32'((i % DEPTH) * 4), $urandom, i == DEPTH + 2);
            runCycle(0, 1);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);  runCycle(0, 0);
        checkOutput("ld_count_saturated", 32'(bus.ld_count), 32'(DEPTH));
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 32'($urandom_range(0, DEPTH - 1)) * 4, 0, 0, 0, 0, 0);
            runCycle(1, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);  runCycle(1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/imem_load_arbiter.md
# imem_load_arbiter

Arbiter and sequencer for the single-port on-chip instruction memory shared by the fetch stage and a program loader (UART/JTAG bridge). In normal operation it forwards fetch read requests to the memory with one-cycle read latency. On a load request it drains the outstanding fetch, holds the core, streams loader words into memory, then releases the core. It sits between the fetch stage and the instruction memory instance.

## Interface
- ADDR_W, 12, word-address width of instruction memory (depth 2**ADDR_W words)
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- f_req  input  1  fetch read request (high whenever core not stalled)
- f_addr  input  32  fetch byte address (PC)
- f_rdata  output  32  instruction word returned
- f_valid  output  1  f_rdata valid (one cycle after accepted f_req)
- f_stall  output  1  fetch request not accepted this cycle
- core_hold  output  1  holds pipeline/PC in reset while memory is owned by loader
- ld_start  input  1  loader requests ownership (pulse)
- ld_valid  input  1  loader word valid
- ld_addr  input  32  loader byte address
- ld_data  input  32  loader word
- ld_last  input  1  qualifies final word of image
- ld_ready  output  1  loader word accepted when ld_valid & ld_ready
- ld_busy  output  1  loader owns memory (DRAIN or LOAD or RELEASE)
- ld_count  output  ADDR_W+1  words written in current/last load
- err  output  1  one-cycle pulse on misaligned or out-of-range access
- mem_address  output  ADDR_W  word address (byte address >> 2)
- mem_chipselect, mem_write, mem_clken  output  1 each  memory controls
- mem_byteenable  output  4  always 4'b1111 when accessing
- mem_writedata  output  32  write data
- mem_readdata  input  32  read data, valid one cycle after read address

## Operation
- States: RUN, DRAIN, LOAD, RELEASE. Reset state RUN.
- RUN: f_stall=0; accepted f_req drives mem_chipselect=1, mem_write=0, mem_address=f_addr[ADDR_W+1:2]. ld_start -> DRAIN (fetch in same cycle still served).
- DRAIN (exactly 1 cycle): no new read issued; pending f_valid delivered; f_stall=1, core_hold=1, ld_busy=1; ld_count cleared to 0 -> LOAD.
- LOAD: ld_ready=1, f_stall=1, core_hold=1. On ld_valid: mem_write=1, mem_address=ld_addr[ADDR_W+1:2], mem_writedata=ld_data, ld_count+1. ld_valid & ld_last -> RELEASE. ld_start ignored.
- RELEASE (1 cycle): ld_ready=0, core_hold=1, no memory access -> RUN; core_hold falls entering RUN so core restarts from PC 0.
- Address checks: access with addr[1:0]!=0 or addr[31:ADDR_W+2]!=0 pulses err the following cycle; the read/write is suppressed (mem_chipselect=0); a suppressed fetch still returns f_valid with f_rdata=32'h0000_0013 (NOP). Suppressed loader words still count as accepted but do not increment ld_count.
- ld_count saturates at 2**ADDR_W; holds value after load until next DRAIN.
- mem_clken=1 always out of reset.

## Timing
- Reset (rst_n low, async): state RUN, f_valid=0, f_rdata=0, f_stall=0, core_hold=0, ld_ready=0, ld_busy=0, ld_count=0, err=0, mem_chipselect=0, mem_write=0, mem_address=0, mem_writedata=0.
- Read latency: f_req accepted at cycle N -> f_valid=1, f_rdata=mem_readdata at N+1. Back-to-back reads sustain one per cycle.
- ld_start at N in RUN: DRAIN at N+1, LOAD at N+2 (ld_ready=1 from N+2).
- Last word accepted at M: RELEASE at M+1, RUN with core_hold=0 at M+2.
- Write accepted in the cycle ld_valid & ld_ready is high; zero-cycle handshake, no buffering.
- Reset mid-load: abort immediately to RUN, partial image retained in memory, ld_count=0.

## Test plan
- Fetch stream: f_req=1, f_addr 0,4,8 on consecutive cycles with memory preloaded 0x11,0x22,0x33 -> f_valid each following cycle with those words, f_stall=0.
- Load handshake: ld_start, then 3 words to addresses 0x0,0x4,0x8 with ld_last on third -> ld_ready at start+2, core_hold high start+1..last+1, ld_count=3, memory readback matches.
- Simultaneous ld_start and f_req at 0x10 -> fetch returns word at 0x10 next cycle, then f_stall=1 from DRAIN on.
- Misaligned fetch 0x6 and loader write to 0x4000 (ADDR_W=12) -> err pulses one cycle each, fetch returns 0x00000013, no memory write, ld_count unchanged.
- rst_n low during LOAD after 2 words -> all outputs at reset values asynchronously, state RUN, words 0–1 retained.
- Sustained load of 4096 words -> ld_count=4096, saturates with extra words.
